rs485_frame_rx: RTL

RS485_FRAME_RX -- requirements
Module: rs485_frame_rx

---
 rtl/rs485_frame_rx_pkg.sv | 15 +
 rtl/rs485_frame_rx_if.sv | 27 ++
 rtl/rs485_frame_rx_crc16_modbus.sv | 20 ++
 rtl/rs485_frame_rx.sv | 136 +++++++++++++
 4 files changed

// File: rtl/rs485_frame_rx_pkg.sv
// Shared types and constants for the RS-485 frame receiver.
package rs485_frame_rx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RECV  = 2'd1,
    ST_CHECK = 2'd2,
    ST_HOLD  = 2'd3
  } state_e;

  localparam logic [15:0] CRC_INIT      = 16'hFFFF;
  localparam logic [15:0] CRC_POLY      = 16'hA001;
  localparam int          MIN_FRAME_LEN = 4;

endpackage

// File: rtl/rs485_frame_rx_if.sv
// Byte input, buffer read port and frame status between receiver and CPU.
interface rs485_frame_rx_if;
  logic [7:0] din_8b_i;
  logic       din_valid_i;
  logic [5:0] rd_addr_6b_i;
  logic       rd_en_i;
  logic [7:0] rd_data_8b_o;
  logic       rd_valid_o;
  logic       ack_i;
  logic       frame_done_o;
  logic       frame_ok_o;
  logic [6:0] frame_len_7b_o;
  logic       overflow_o;
  logic       drop_o;

  modport master (
    output din_8b_i, din_valid_i, rd_addr_6b_i, rd_en_i, ack_i,
    input  rd_data_8b_o, rd_valid_o, frame_done_o, frame_ok_o,
           frame_len_7b_o, overflow_o, drop_o
  );

  modport slave (
    input  din_8b_i, din_valid_i, rd_addr_6b_i, rd_en_i, ack_i,
    output rd_data_8b_o, rd_valid_o, frame_done_o, frame_ok_o,
           frame_len_7b_o, overflow_o, drop_o
  );
endinterface

// File: rtl/rs485_frame_rx_crc16_modbus.sv
// One-byte CRC-16/MODBUS update, fully combinational (8 unrolled bit steps).
module crc16_modbus
  import rs485_frame_rx_pkg::*;
(
  input  logic [15:0] crc_in_i,
  input  logic [7:0]  byte_8b_i,
  output logic [15:0] crc_out_o
);

  logic [15:0] c;

  always_comb begin
    c = crc_in_i ^ {8'h00, byte_8b_i};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
    end
    crc_out_o = c;
  end

endmodule

// File: rtl/rs485_frame_rx.sv
// Modbus-RTU style frame receiver: buffers bytes, ends a frame on an idle gap,
// checks length/CRC and holds the result until the CPU acknowledges.
module rs485_frame_rx
  import rs485_frame_rx_pkg::*;
#(
  parameter int GAP_CYCLES = 200521,
  parameter int BUF_DEPTH  = 64
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  rs485_frame_rx_if.slave  bus
);

  localparam int             AW       = $clog2(BUF_DEPTH);
  localparam int             GW       = (GAP_CYCLES > 2) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GW-1:0]  GAP_LAST = GW'(GAP_CYCLES - 1);
  localparam logic [6:0]     LEN_MAX  = 7'(BUF_DEPTH);

  state_e         state_q, state_d;
  logic [6:0]     len_q, len_d;
  logic [15:0]    crc_q, crc_d, crc_in, crc_nxt;
  logic [GW-1:0]  gap_q, gap_d;
  logic           ok_q, ok_d, ovf_q, ovf_d, drop_q, drop_d, done_q, done_d;
  logic           rd_vld_q;
  logic           we;
  logic [AW-1:0]  waddr;
  logic [7:0]     mem [BUF_DEPTH];
  logic [7:0]     rd_raw_q;

  // A new frame always restarts from the init value, whatever crc_q holds.
  assign crc_in = (state_q == ST_IDLE) ? CRC_INIT : crc_q;

  crc16_modbus u_crc (
    .crc_in_i  (crc_in),
    .byte_8b_i (bus.din_8b_i),
    .crc_out_o (crc_nxt)
  );

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    crc_d   = crc_q;
    gap_d   = gap_q;
    ok_d    = ok_q;
    ovf_d   = ovf_q;
    drop_d  = drop_q;
    done_d  = 1'b0;
    we      = 1'b0;
    waddr   = len_q[AW-1:0];
    case (state_q)
      ST_IDLE: if (bus.din_valid_i) begin
        we      = 1'b1;
        waddr   = '0;
        len_d   = 7'd1;
        crc_d   = crc_nxt;
        gap_d   = '0;
        state_d = ST_RECV;
      end
      ST_RECV: begin
        // A byte on the terminal gap count still wins over ending the frame.
        if (bus.din_valid_i) begin
          crc_d = crc_nxt;
          gap_d = '0;
          if (len_q < LEN_MAX) begin
            we    = 1'b1;
            len_d = len_q + 7'd1;
          end else begin
            ovf_d = 1'b1;
          end
        end else if (gap_q == GAP_LAST) begin
          state_d = ST_CHECK;
        end else begin
          gap_d = gap_q + GW'(1);
        end
      end
      ST_CHECK: begin
        ok_d    = (len_q >= 7'(MIN_FRAME_LEN)) && (crc_q == 16'h0000) && !ovf_q;
        done_d  = 1'b1;
        state_d = ST_HOLD;
      end
      ST_HOLD: begin
        if (bus.ack_i) begin
          state_d = ST_IDLE;
          len_d   = '0;
          crc_d   = CRC_INIT;
          gap_d   = '0;
          ok_d    = 1'b0;
          ovf_d   = 1'b0;
          drop_d  = 1'b0;
        end else if (bus.din_valid_i) begin
          drop_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q  <= ST_IDLE;
      len_q    <= '0;
      crc_q    <= CRC_INIT;
      gap_q    <= '0;
      ok_q     <= 1'b0;
      ovf_q    <= 1'b0;
      drop_q   <= 1'b0;
      done_q   <= 1'b0;
      rd_vld_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      len_q    <= len_d;
      crc_q    <= crc_d;
      gap_q    <= gap_d;
      ok_q     <= ok_d;
      ovf_q    <= ovf_d;
      drop_q   <= drop_d;
      done_q   <= done_d;
      rd_vld_q <= bus.rd_en_i;
    end
  end

  // Plain synchronous RAM; contents survive reset.
  always_ff @(posedge clk_i) begin
    if (we)          mem[waddr] <= bus.din_8b_i;
    if (bus.rd_en_i) rd_raw_q   <= mem[bus.rd_addr_6b_i[AW-1:0]];
  end

  assign bus.rd_data_8b_o   = rd_vld_q ? rd_raw_q : 8'h00;
  assign bus.rd_valid_o     = rd_vld_q;
  assign bus.frame_done_o   = done_q;
  assign bus.frame_ok_o     = ok_q;
  assign bus.frame_len_7b_o = len_q;
  assign bus.overflow_o     = ovf_q;
  assign bus.drop_o         = drop_q;

endmodule
